// File: rtl/imuldiv_div_issuer_pkg.sv
// Shared imuldiv message header: divide-request function codes, the
// pipeline op_kind encodings that map onto them, and the issuer FSM states.
package imuldiv_div_issuer_pkg;

    // DivReqMsg function field
    localparam logic FUNC_SIGNED   = 1'b0;
    localparam logic FUNC_UNSIGNED = 1'b1;

    // Pipeline op_kind encodings.
    // Bit 0 selects unsigned and lines up with the DivReqMsg function field.
    // Bit 1 selects the remainder half of the response.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WB    = 2'b11
    } issuer_state_e;

    // A divide by zero writes back an all-ones quotient.
    localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

    function automatic logic kind_is_rem(input logic [1:0] kind);
        return kind[1];
    endfunction

    function automatic logic kind_to_fn(input logic [1:0] kind);
        return kind[0] ? FUNC_UNSIGNED : FUNC_SIGNED;
    endfunction

endpackage

// File: rtl/imuldiv_div_issuer_ctrl.sv
// Sequencing FSM for the divide issuer. It owns the handshake valid/ready
// flags and emits the load, select and counter enables for the datapath.
//
//   state | meaning
//   IDLE  | ready for a new operation from the pipeline
//   ISSUE | divide request presented, waiting for divreq_rdy
//   WAIT  | request taken, waiting for the divide response
//   WB    | writeback presented, waiting for wb_rdy
module imuldiv_DivIssuerCtrl
    import imuldiv_div_issuer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic op_val_i,
    input  logic b_is_zero_i,
    input  logic divreq_rdy_i,
    input  logic divresp_val_i,
    input  logic wb_rdy_i,
    output logic op_rdy_o,
    output logic divreq_val_o,
    output logic divresp_rdy_o,
    output logic wb_val_o,
    output logic op_load_o,
    output logic res_load_o,
    output logic res_sel_bypass_o,
    output logic cnt_clr_o,
    output logic cnt_inc_o
);

    issuer_state_e state_q;
    logic          op_rdy_q;
    logic          divreq_val_q;
    logic          divresp_rdy_q;
    logic          wb_val_q;
    logic          capture;

    // op_rdy_q comes out of reset set, so reset masks it here: the output is
    // low while reset is asserted and high on the first cycle after it.
    assign op_rdy_o      = op_rdy_q & ~reset;
    assign divreq_val_o  = divreq_val_q;
    assign divresp_rdy_o = divresp_rdy_q;
    assign wb_val_o      = wb_val_q;

    assign op_load_o        = (state_q == ST_IDLE) & op_val_i & op_rdy_o;
    assign capture          = (state_q == ST_WAIT) & divresp_val_i;
    assign res_load_o       = (op_load_o & b_is_zero_i) | capture;
    assign res_sel_bypass_o = op_load_o;
    assign cnt_clr_o        = op_load_o;
    assign cnt_inc_o        = (state_q == ST_ISSUE) | (state_q == ST_WAIT);

    // State register with the handshake flags registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_rdy_q      <= 1'b1;
            divreq_val_q  <= 1'b0;
            divresp_rdy_q <= 1'b0;
            wb_val_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_load_o) begin
                        op_rdy_q <= 1'b0;
                        if (b_is_zero_i) begin
                            state_q  <= ST_WB;
                            wb_val_q <= 1'b1;
                        end else begin
                            state_q      <= ST_ISSUE;
                            divreq_val_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (divreq_rdy_i) begin
                        state_q       <= ST_WAIT;
                        divreq_val_q  <= 1'b0;
                        divresp_rdy_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (divresp_val_i) begin
                        state_q       <= ST_WB;
                        divresp_rdy_q <= 1'b0;
                        wb_val_q      <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (wb_rdy_i) begin
                        state_q  <= ST_IDLE;
                        wb_val_q <= 1'b0;
                        op_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    op_rdy_q      <= 1'b1;
                    divreq_val_q  <= 1'b0;
                    divresp_rdy_q <= 1'b0;
                    wb_val_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_div_issuer.sv
// Requester-side front end for the iterative divider. It holds one divide or
// remainder op, issues it over divreq, picks the requested half of the
// response, and returns it with its tag and a saturating issue-to-capture
// cycle count.
module imuldiv_div_issuer
    import imuldiv_div_issuer_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_val,
    output logic             op_rdy,
    input  logic [1:0]       op_kind,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] op_tag,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    input  logic [63:0]      divresp_msg_result,
    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic [CNT_W-1:0] wb_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       kind_q, kind_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        b_is_zero;
    logic        op_load, res_load, res_sel_bypass, cnt_clr, cnt_inc;
    logic [31:0] bypass_data;
    logic [31:0] resp_data;

    // The zero-divisor decision is made on the incoming operand at accept.
    assign b_is_zero   = (op_b == 32'd0);
    assign bypass_data = kind_is_rem(op_kind) ? op_a : DIV_BY_ZERO_QUOT;
    assign resp_data   = kind_is_rem(kind_q) ? divresp_msg_result[63:32]
                                             : divresp_msg_result[31:0];

    imuldiv_DivIssuerCtrl u_ctrl (
        .clk              (clk),
        .reset            (reset),
        .op_val_i         (op_val),
        .b_is_zero_i      (b_is_zero),
        .divreq_rdy_i     (divreq_rdy),
        .divresp_val_i    (divresp_val),
        .wb_rdy_i         (wb_rdy),
        .op_rdy_o         (op_rdy),
        .divreq_val_o     (divreq_val),
        .divresp_rdy_o    (divresp_rdy),
        .wb_val_o         (wb_val),
        .op_load_o        (op_load),
        .res_load_o       (res_load),
        .res_sel_bypass_o (res_sel_bypass),
        .cnt_clr_o        (cnt_clr),
        .cnt_inc_o        (cnt_inc)
    );

    // Next-state for operand, result and latency registers.
    always_comb begin
        kind_d    = kind_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        if (op_load) begin
            kind_d = op_kind;
            a_d    = op_a;
            b_d    = op_b;
            tag_d  = op_tag;
        end
        if (res_load) begin
            wb_data_d = res_sel_bypass ? bypass_data : resp_data;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            wb_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            kind_q    <= kind_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign divreq_msg_fn = kind_to_fn(kind_q);
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;
    assign wb_data       = wb_data_q;
    assign wb_tag        = tag_q;
    assign wb_cycles     = cnt_q;

endmodule

// File: tb/tb_imuldiv_div_issuer.sv
// Directed bench for imuldiv_div_issuer. The bench plays the pipeline, the
// divide unit and the writeback consumer; a behavioural model gives the
// expected writeback and request message, checked every cycle they are valid.
module tb_imuldiv_div_issuer;

    localparam int TAG_W = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             op_val;
    logic             op_rdy;
    logic [1:0]       op_kind;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [TAG_W-1:0] op_tag;
    logic             divreq_val;
    logic             divreq_rdy;
    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a;
    logic [31:0]      divreq_msg_b;
    logic             divresp_val;
    logic             divresp_rdy;
    logic [63:0]      divresp_msg_result;
    logic             wb_val;
    logic             wb_rdy;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [CNT_W-1:0] wb_cycles;

    int errors = 0;
    int checks = 0;

    // Model expectations for the op in flight
    logic             mon_en = 1'b0;
    logic [31:0]      exp_data;
    logic [TAG_W-1:0] exp_tag;
    logic [CNT_W-1:0] exp_cyc;
    logic             exp_fn;
    logic [31:0]      exp_a;
    logic [31:0]      exp_b;
    logic             exp_bypass = 1'b0;
    logic [31:0]      last_data = 32'd0;

    imuldiv_div_issuer #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .op_val             (op_val),
        .op_rdy             (op_rdy),
        .op_kind            (op_kind),
        .op_a               (op_a),
        .op_b               (op_b),
        .op_tag             (op_tag),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .divresp_msg_result (divresp_msg_result),
        .wb_val             (wb_val),
        .wb_rdy             (wb_rdy),
        .wb_data            (wb_data),
        .wb_tag             (wb_tag),
        .wb_cycles          (wb_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference divider: {remainder, quotient}, C-style truncation for signed.
    function automatic logic [63:0] div_model(input logic [1:0] k, input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa, sb;
        logic [31:0] q, r;
        if (k[0] == 1'b0) begin
            sa = int'(a);
            sb = int'(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] wb_model(input logic [1:0] k, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] res;
        if (b == 32'd0) return k[1] ? a : 32'hFFFF_FFFF;
        res = div_model(k, a, b);
        return k[1] ? res[63:32] : res[31:0];
    endfunction

    function automatic logic [CNT_W-1:0] cyc_model(input int issue_cycles, input int wait_cycles);
        int t;
        t = issue_cycles + wait_cycles;
        return (t > 255) ? 8'd255 : CNT_W'(t);
    endfunction

    // Every cycle: a valid writeback or request must match the model.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (wb_val) begin
                chk("mon_wb_data", wb_data, exp_data);
                chk("mon_wb_tag", wb_tag, exp_tag);
                chk("mon_wb_cycles", wb_cycles, exp_cyc);
            end
            if (divreq_val) begin
                chk("mon_divreq_fn", divreq_msg_fn, exp_fn);
                chk("mon_divreq_a", divreq_msg_a, exp_a);
                chk("mon_divreq_b", divreq_msg_b, exp_b);
            end
            if (exp_bypass) chk("mon_bypass_no_divreq", divreq_val, 1'b0);
        end
    end

    // One op: s = cycles divreq_rdy is held low, d = response delay after the
    // request handshake, w = cycles wb_rdy is held low, spur = drive a bogus
    // response while it must be ignored. lit_* are hand-computed results.
    task automatic run_op(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int s, input int d, input int w,
                          input bit spur, input logic [31:0] lit_data,
                          input logic [CNT_W-1:0] lit_cyc);
        int n;
        exp_fn     = k[0];
        exp_a      = a;
        exp_b      = b;
        exp_tag    = tag;
        exp_bypass = (b == 32'd0);
        exp_data   = wb_model(k, a, b);
        exp_cyc    = exp_bypass ? 8'd0 : cyc_model(s + 1, d);
        n = 0;
        while (!op_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_rdy_in_idle", op_rdy, 1'b1);
        if (spur) begin
            divresp_val        = 1'b1;
            divresp_msg_result = 64'hBADC0DE0_DEADBEEF;
            chk("divresp_rdy_idle", divresp_rdy, 1'b0);
        end
        op_val  = 1'b1;
        op_kind = k;
        op_a    = a;
        op_b    = b;
        op_tag  = tag;
        @(negedge clk);
        op_val = 1'b0;
        op_a   = 32'h5A5A_5A5A;
        op_b   = 32'hA5A5_A5A5;
        op_tag = ~tag;
        chk("op_rdy_after_accept", op_rdy, 1'b0);
        if (spur) chk("no_capture_idle", wb_data, last_data);
        if (b != 32'd0) begin
            chk("divreq_val_accept_plus1", divreq_val, 1'b1);
            for (int i = 0; i < s; i++) begin
                @(negedge clk);
                chk("divreq_val_stall", divreq_val, 1'b1);
                chk("op_rdy_stall", op_rdy, 1'b0);
                chk("divresp_rdy_issue", divresp_rdy, 1'b0);
            end
            divreq_rdy = 1'b1;
            @(negedge clk);
            divreq_rdy = 1'b0;
            chk("divreq_val_after_hs", divreq_val, 1'b0);
            chk("divresp_rdy_wait", divresp_rdy, 1'b1);
            chk("wb_val_wait", wb_val, 1'b0);
            if (spur) chk("no_capture_issue", wb_data, last_data);
            divresp_val = 1'b0;
            for (int i = 1; i < d; i++) @(negedge clk);
            divresp_val        = 1'b1;
            divresp_msg_result = div_model(k, a, b);
            @(negedge clk);
            divresp_val        = 1'b0;
            divresp_msg_result = 64'h0123_4567_89AB_CDEF;
            chk("divresp_rdy_after_capture", divresp_rdy, 1'b0);
        end else begin
            chk("bypass_no_divreq", divreq_val, 1'b0);
        end
        chk("wb_val_latency", wb_val, 1'b1);
        chk("lit_wb_data", wb_data, lit_data);
        chk("lit_wb_cycles", wb_cycles, lit_cyc);
        chk("lit_wb_tag", wb_tag, tag);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            chk("wb_val_stall", wb_val, 1'b1);
            chk("op_rdy_wb_stall", op_rdy, 1'b0);
        end
        wb_rdy = 1'b1;
        @(negedge clk);
        wb_rdy = 1'b0;
        chk("wb_val_after_accept", wb_val, 1'b0);
        chk("op_rdy_after_wb", op_rdy, 1'b1);
        last_data = exp_data;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        op_val             = 1'b0;
        op_kind            = 2'b00;
        op_a               = 32'd0;
        op_b               = 32'd0;
        op_tag             = '0;
        divreq_rdy         = 1'b0;
        divresp_val        = 1'b0;
        divresp_msg_result = 64'd0;
        wb_rdy             = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_op_rdy", op_rdy, 1'b0);
        chk("rst_divreq_val", divreq_val, 1'b0);
        chk("rst_divresp_rdy", divresp_rdy, 1'b0);
        chk("rst_wb_val", wb_val, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_op_rdy", op_rdy, 1'b1);
        chk("post_rst_msg_fn", divreq_msg_fn, 1'b0);
        chk("post_rst_msg_a", divreq_msg_a, 32'd0);
        chk("post_rst_msg_b", divreq_msg_b, 32'd0);
        chk("post_rst_wb_data", wb_data, 32'd0);
        chk("post_rst_wb_tag", wb_tag, 5'd0);
        chk("post_rst_wb_cycles", wb_cycles, 8'd0);

        // Hand-computed points that pin the model itself
        chk("model_div_neg", wb_model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem_neg", wb_model(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_remu", wb_model(2'b11, 32'hFFFF_FFFF, 32'd10), 32'd5);
        chk("model_sat", cyc_model(1, 300), 8'd255);

        mon_en = 1'b1;

        // signed div -7/2, response 33 cycles after the request handshake
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 33, 0, 1'b0, 32'hFFFF_FFFD, 8'd34);
        // remu 0xFFFFFFFF % 10
        run_op(2'b11, 32'hFFFF_FFFF, 32'd10, 5'd7, 0, 5, 0, 1'b0, 32'd5, 8'd6);
        // zero divisor bypass, div and rem
        run_op(2'b00, 32'd9, 32'd0, 5'd1, 0, 0, 0, 1'b0, 32'hFFFF_FFFF, 8'd0);
        run_op(2'b10, 32'd9, 32'd0, 5'd2, 0, 0, 0, 1'b0, 32'd9, 8'd0);
        // backpressure: 5 request stall cycles, 4 writeback stall cycles
        run_op(2'b01, 32'd100, 32'd7, 5'd4, 5, 3, 4, 1'b0, 32'd14, 8'd9);
        // spurious responses in IDLE, ISSUE and on the handshake cycle
        run_op(2'b10, 32'hFFFF_FFEC, 32'd6, 5'd5, 2, 4, 1, 1'b1, 32'hFFFF_FFFE, 8'd7);

        // reset while waiting for the response aborts the op
        exp_fn     = 1'b0;
        exp_a      = 32'd100;
        exp_b      = 32'd7;
        exp_tag    = 5'd9;
        exp_bypass = 1'b0;
        op_val  = 1'b1;
        op_kind = 2'b00;
        op_a    = 32'd100;
        op_b    = 32'd7;
        op_tag  = 5'd9;
        @(negedge clk);
        op_val     = 1'b0;
        divreq_rdy = 1'b1;
        @(negedge clk);
        divreq_rdy = 1'b0;
        chk("abort_in_wait", divresp_rdy, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_op_rdy", op_rdy, 1'b0);
        chk("abort_rst_divresp_rdy", divresp_rdy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_op_rdy", op_rdy, 1'b1);
        chk("abort_wb_val", wb_val, 1'b0);
        chk("abort_wb_data", wb_data, 32'd0);
        chk("abort_wb_tag", wb_tag, 5'd0);
        chk("abort_wb_cycles", wb_cycles, 8'd0);
        chk("abort_msg_a", divreq_msg_a, 32'd0);
        last_data = 32'd0;

        // slow divider: counter saturates, data still correct
        run_op(2'b01, 32'd1000, 32'd3, 5'd6, 0, 300, 0, 1'b0, 32'd333, 8'd255);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imuldiv_div_issuer.md
# imuldiv_div_issuer

Requester-side front end for the iterative divide unit. Accepts one 32-bit divide/remainder operation from the execute stage and issues it as a divide request over val/rdy. It then waits for the 64-bit `{remainder, quotient}` response, selects the requested half, and returns a 32-bit writeback with the destination tag and a measured latency. The block sits between the pipeline X stage and the divide unit and drives the opposite end of the divide-unit `divreq`/`divresp` handshake.

## Interface

Parameters:
- TAG_W, 5, width of the destination register tag.
- CNT_W, 8, width of the saturating latency counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_val  in  1  pipeline offers an operation
- op_rdy  out  1  block can accept an operation
- op_kind  in  2  00 div, 01 divu, 10 rem, 11 remu
- op_a  in  32  dividend
- op_b  in  32  divisor
- op_tag  in  TAG_W  destination tag
- divreq_val  out  1  request valid to the divide unit
- divreq_rdy  in  1  divide unit accepts the request
- divreq_msg_fn  out  1  0 = signed, 1 = unsigned (shared DivReqMsg encoding)
- divreq_msg_a  out  32  dividend
- divreq_msg_b  out  32  divisor
- divresp_val  in  1  divide unit has a result
- divresp_rdy  out  1  block accepts the result
- divresp_msg_result  in  64  `{rem[31:0], quot[31:0]}`
- wb_val  out  1  writeback valid
- wb_rdy  in  1  writeback consumer ready
- wb_data  out  32  selected quotient or remainder
- wb_tag  out  TAG_W  tag of the completed op
- wb_cycles  out  CNT_W  cycles from issue to result capture, saturating

## Operation

- The FSM has four states: IDLE, ISSUE, WAIT and WB. The block holds at most one operation in flight.
- IDLE:
  - op_rdy = 1.
  - On op_val&&op_rdy the block registers kind, a, b and tag, and clears the counter.
  - If b == 0, it goes to WB directly (zero-divisor bypass). Otherwise it goes to ISSUE.
- ISSUE:
  - divreq_val = 1, and the message is driven from registers.
  - divreq_msg_fn = op_kind[0].
  - On divreq_rdy the block goes to WAIT.
- WAIT:
  - divresp_rdy = 1.
  - On divresp_val the block captures the result into the wb_data register and goes to WB.
  - Capture selection: kind[1]=0 selects result[31:0]; kind[1]=1 selects result[63:32].
- WB:
  - wb_val = 1.
  - On wb_rdy the block returns to IDLE.
  - op_rdy stays 0 in WB, so there is no back-to-back overlap.
- Zero-divisor bypass values:
  - div/divu: wb_data = 32'hFFFF_FFFF.
  - rem/remu: wb_data = op_a.
  - wb_cycles = 0.
  - No divreq is issued.
- Counter:
  - Increments every cycle in ISSUE and WAIT, including the capture cycle.
  - Saturates at 2^CNT_W-1.
  - wb_cycles is the registered counter value and is held through WB.
- Outputs not active in a state are 0. divreq_msg_* and wb_data/wb_tag are held from their registers at all times.

## Timing

- Reset:
  - State goes to IDLE.
  - All registers are cleared: divreq_msg_* = 0, wb_data = 0, wb_tag = 0, wb_cycles = 0.
  - divreq_val, divresp_rdy and wb_val are 0.
  - op_rdy is 0 while reset is high and 1 from the first cycle after reset.
- Latency:
  - Accept at cycle N gives divreq_val at N+1.
  - A response captured at cycle M gives wb_val at M+1.
  - The bypass case gives wb_val at N+1.
- Handshake rules:
  - A transfer happens only on a cycle where val&&rdy. val never depends combinationally on rdy.
  - divreq_msg_* stays stable while divreq_val=1 and not accepted.
  - wb_* stays stable while wb_val=1 and not accepted.
- divresp_val seen in IDLE, ISSUE or WB is ignored (divresp_rdy=0) and not captured.
- divreq_rdy and divresp_val high in the same ISSUE cycle: only the request transfers. The response is taken the next cycle in WAIT.
- Reset mid-operation from any state aborts the operation. No writeback is produced, and the divide unit is reset by the same reset.
- The counter reaching saturation during WAIT holds the maximum value. There is no timeout and no error.

## Structure

- Add op_kind encodings (DIV, DIVU, REM, REMU) as constants to the shared imuldiv message header, next to the existing DivReqMsg function constants. Reuse FUNC_SIGNED/FUNC_UNSIGNED from there.
- Split the block into a datapath (operand, tag, result and counter registers, result select) and one sub-module for the FSM, imuldiv_DivIssuerCtrl. The FSM emits enables and selects and receives b_is_zero.

## Test plan

- Signed div: a=-7, b=2, tag=3, with the iterative divider attached.
  - The divider returns {-1,-3}, so wb_data=32'hFFFF_FFFD and wb_tag=3.
  - The divider raises divresp_val 33 cycles after the request handshake, so wb_cycles=34.
- remu: a=32'hFFFF_FFFF, b=10 → divreq_msg_fn=1, wb_data=5.
- Zero divisor: div a=9, b=0 → no divreq_val, wb_val at accept+1, wb_data=32'hFFFF_FFFF, wb_cycles=0. rem a=9, b=0 → wb_data=9.
- Backpressure:
  - Hold divreq_rdy=0 for 5 cycles, then hold wb_rdy=0 for 4 cycles.
  - Required response: divreq_msg and wb outputs stay stable, op_rdy stays 0, and wb_cycles includes the 5 stall cycles.
- Spurious divresp_val=1 in IDLE and ISSUE → divresp_rdy=0 and the result is not captured. Assert reset in WAIT → next cycle op_rdy=1, wb_val=0.
- Stub divider that delays the response 300 cycles → wb_cycles=255 (saturated), with the correct data.
